// File: rtl/pmod_led_pattern.sv
// pmod_led_pattern: multi-mode LED pattern generator for PMOD_NUM 8-LED PMOD boards.
// A debounced active-low key cycles through four modes (rotate left, rotate right,
// bounce, binary count). Each channel shows the pattern rotated left by c*CH_OFFSET.
// LEDs are active-low (lit = 0).
// Optional feature: define PMOD_LED_PWM_EN to add a PWM brightness control
// (adds parameter PWM_BITS and input pwm_duty).
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   key       raw push-button, active-low, asynchronous to clk
//   pause     level; 1 freezes pattern and step counter
//   pwm_duty  brightness duty (PMOD_LED_PWM_EN builds only)
//   led_tick  toggles on every applied pattern step
//   led_mode  current mode
//   pmod_io   channel c on [c*LED_W +: LED_W]
module pmod_led_pattern #(
    parameter int unsigned PMOD_NUM    = 8,
    parameter int unsigned LED_W       = 8,
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned STEP_HZ     = 5,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned CH_OFFSET   = 0
`ifdef PMOD_LED_PWM_EN
    ,parameter int unsigned PWM_BITS   = 4
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key,
    input  logic                      pause,
`ifdef PMOD_LED_PWM_EN
    input  logic [PWM_BITS-1:0]       pwm_duty,
`endif
    output logic                      led_tick,
    output logic [1:0]                led_mode,
    output logic [PMOD_NUM*LED_W-1:0] pmod_io
);

    localparam int unsigned STEP_DIV = CLK_FREQ / STEP_HZ;
    localparam int unsigned DEB_CYC  = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int unsigned STEP_W   = $clog2(STEP_DIV);
    localparam int unsigned DEB_W    = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v, input int unsigned s);
        logic [LED_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
            r[(i + s) % LED_W] = v[i];
        end
        return r;
    endfunction

    function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
        case (m)
            MODE_ROT_R: return {1'b1, {(LED_W-1){1'b0}}};
            MODE_COUNT: return '0;
            default:    return LED_W'(1);
        endcase
    endfunction

    // Key synchroniser; idle level is high (released)
    logic key_meta, key_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Debouncer: flip only after DEB_CYC consecutive differing samples
    logic             deb_pressed;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_diff_c, deb_flip_c, press_c;

    assign deb_diff_c = (~key_sync) != deb_pressed;
    assign deb_flip_c = deb_diff_c && (deb_cnt == DEB_W'(DEB_CYC - 1));
    assign press_c    = deb_flip_c && !deb_pressed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_pressed <= 1'b0;
            deb_cnt     <= '0;
        end else if (!deb_diff_c) begin
            deb_cnt     <= '0;
        end else if (deb_flip_c) begin
            deb_pressed <= ~deb_pressed;
            deb_cnt     <= '0;
        end else begin
            deb_cnt     <= deb_cnt + DEB_W'(1);
        end
    end

    // Mode / pattern state register
    mode_t             mode_q, mode_d;
    logic [LED_W-1:0]  pattern_q, pattern_d;
    logic              dir_down_q, dir_down_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              tick_d;
    logic              step_c;

    assign step_c = !pause && (step_cnt_q == STEP_W'(STEP_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_ROT_L;
            pattern_q  <= LED_W'(1);
            dir_down_q <= 1'b0;
            step_cnt_q <= '0;
            led_tick   <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            dir_down_q <= dir_down_d;
            step_cnt_q <= step_cnt_d;
            led_tick   <= tick_d;
        end
    end

    // Next-state: a press overrides a coincident step
    always_comb begin
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        dir_down_d = dir_down_q;
        step_cnt_d = step_cnt_q;
        tick_d     = led_tick;
        if (press_c) begin
            mode_d     = mode_t'(mode_q + 2'd1);
            pattern_d  = init_pattern(mode_d);
            dir_down_d = 1'b0;
            step_cnt_d = '0;
        end else if (step_c) begin
            step_cnt_d = '0;
            tick_d     = ~led_tick;
            case (mode_q)
                MODE_ROT_L: pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
                MODE_ROT_R: pattern_d = {pattern_q[0], pattern_q[LED_W-1:1]};
                MODE_BOUNCE: begin
                    // Direction flips on the step that lands on an end LED
                    if (!dir_down_q) begin
                        pattern_d = pattern_q << 1;
                        if (pattern_d[LED_W-1]) dir_down_d = 1'b1;
                    end else begin
                        pattern_d = pattern_q >> 1;
                        if (pattern_d[0]) dir_down_d = 1'b0;
                    end
                end
                default: pattern_d = pattern_q + LED_W'(1);
            endcase
        end else if (!pause) begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
        end
    end

    assign led_mode = mode_q;

    // Brightness gate
    logic pwm_on_c;
`ifdef PMOD_LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
    assign pwm_on_c = pwm_cnt < pwm_duty;
`else
    assign pwm_on_c = 1'b1;
`endif

    // Per-channel rotated, inverted output
    logic [PMOD_NUM*LED_W-1:0] pmod_d;
    always_comb begin
        pmod_d = '0;
        for (int unsigned c = 0; c < PMOD_NUM; c++) begin
            pmod_d[c*LED_W +: LED_W] =
                ~(rotl(pattern_q, (c * CH_OFFSET) % LED_W) & {LED_W{pwm_on_c}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < PMOD_NUM; c++) begin
                pmod_io[c*LED_W +: LED_W] <= ~rotl(LED_W'(1), (c * CH_OFFSET) % LED_W);
            end
        end else begin
            pmod_io <= pmod_d;
        end
    end

endmodule

// File: tb/tb_pmod_led_pattern.sv
// Directed bench for pmod_led_pattern with STEP_DIV=10, DEB_CYC=10, 2 channels, CH_OFFSET=1.
module tb_pmod_led_pattern;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic        pause;
    logic        led_tick;
    logic [1:0]  led_mode;
    logic [15:0] pmod_io;
`ifdef PMOD_LED_PWM_EN
    logic [3:0]  pwm_duty;
`endif

    int tests = 0;
    int fails = 0;

    pmod_led_pattern #(
        .PMOD_NUM   (2),
        .LED_W      (8),
        .CLK_FREQ   (10_000),
        .STEP_HZ    (1000),
        .DEBOUNCE_MS(1),
        .CH_OFFSET  (1)
`ifdef PMOD_LED_PWM_EN
        ,.PWM_BITS  (4)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .pause   (pause),
`ifdef PMOD_LED_PWM_EN
        .pwm_duty(pwm_duty),
`endif
        .led_tick(led_tick),
        .led_mode(led_mode),
        .pmod_io (pmod_io)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] bexp [14];
    logic [7:0] inv;
    int         lit;

    initial begin
        bexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        rst   = 1'b1;
        key   = 1'b1;
        pause = 1'b0;
`ifdef PMOD_LED_PWM_EN
        pwm_duty = 4'd4;
`endif
        tick(3);
        check("rst_pmod", 32'(pmod_io), 32'h0000FDFE);
        check("rst_mode", 32'(led_mode), 32'd0);
        check("rst_tick", 32'(led_tick), 32'd0);
`ifdef PMOD_LED_PWM_EN
        // Pattern frozen at 0x01 so only the PWM gate moves bit 0
        pause = 1'b1;
        rst   = 1'b0;
        tick(2);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (pmod_io[0] == 1'b0) lit++;
        end
        check("pwm_duty4_lit", 32'(lit), 32'd4);
        pwm_duty = 4'd0;
        tick(2);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (pmod_io[7:0] != 8'hFF) lit++;
        end
        check("pwm_duty0_dark", 32'(lit), 32'd0);
`else
        rst = 1'b0;
        // Steps at edges 10,20,30; display lags pattern by one cycle
        tick(30);
        check("t1_tick", 32'(led_tick), 32'd1);
        tick(1);
        check("t1_ch0", 32'(pmod_io[7:0]), 32'hF7);
        check("t1_ch1", 32'(pmod_io[15:8]), 32'hEF);
        tick(50);
        check("t2_ch0_wrap", 32'(pmod_io[7:0]), 32'hFE);
        check("t2_ch1_wrap", 32'(pmod_io[15:8]), 32'hFD);
        check("t2_tick", 32'(led_tick), 32'd0);

        // Short glitch ignored
        key = 1'b0;
        tick(5);
        key = 1'b1;
        tick(15);
        check("t3_glitch_mode", 32'(led_mode), 32'd0);

        // Real press: flips on the 12th edge (2 sync + 10 debounce)
        key = 1'b0;
        tick(11);
        check("t3_deb_edge_mode", 32'(led_mode), 32'd0);
        tick(1);
        check("t3_press_mode", 32'(led_mode), 32'd1);
        tick(1);
        check("t3_rotr_ch0", 32'(pmod_io[7:0]), 32'h7F);
        check("t3_rotr_ch1", 32'(pmod_io[15:8]), 32'hFE);
        tick(200);
        check("t3_hold_mode", 32'(led_mode), 32'd1);
        key = 1'b1;
        tick(20);

        // Second press -> BOUNCE
        key = 1'b0;
        tick(12);
        check("t4_mode", 32'(led_mode), 32'd2);
        tick(1);
        check("t4_init_ch0", 32'(pmod_io[7:0]), 32'hFE);
        for (int k = 0; k < 14; k++) begin
            tick(10);
            inv = ~bexp[k];
            check($sformatf("t4_bounce_%0d", k), 32'(pmod_io[7:0]), 32'(inv));
        end
        key = 1'b1;
        tick(20);

        // COUNT mode with full 8-bit wrap
        key = 1'b0;
        tick(12);
        check("t5_mode", 32'(led_mode), 32'd3);
        key = 1'b1;
        tick(1);
        check("t5_init_ch0", 32'(pmod_io[7:0]), 32'hFF);
        tick(30);
        check("t5_count3_ch0", 32'(pmod_io[7:0]), 32'hFC);
        tick(2520);
        check("t5_count255_ch0", 32'(pmod_io[7:0]), 32'h00);
        tick(10);
        check("t5_wrap_ch0", 32'(pmod_io[7:0]), 32'hFF);
        tick(20);
        key = 1'b0;
        tick(12);
        check("t5_mode_wrap", 32'(led_mode), 32'd0);
        key = 1'b1;
        tick(1);
        check("t5_rotl_init_ch0", 32'(pmod_io[7:0]), 32'hFE);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        check("rst2_mode", 32'(led_mode), 32'd0);
        check("rst2_pmod", 32'(pmod_io), 32'h0000FDFE);
        tick(2);
        rst = 1'b0;
        tick(15);
        check("p_pre_ch0", 32'(pmod_io[7:0]), 32'hFD);
        pause = 1'b1;
        tick(50);
        check("p_hold_ch0", 32'(pmod_io[7:0]), 32'hFD);
        check("p_hold_tick", 32'(led_tick), 32'd1);
        pause = 1'b0;
        tick(5);
        check("p_resume_tick", 32'(led_tick), 32'd0);
        tick(1);
        check("p_resume_ch0", 32'(pmod_io[7:0]), 32'hFB);

        // Press acts while paused
        pause = 1'b1;
        key   = 1'b0;
        tick(12);
        check("p_press_mode", 32'(led_mode), 32'd1);
        tick(1);
        check("p_press_ch0", 32'(pmod_io[7:0]), 32'h7F);
        key = 1'b1;
        tick(20);
        check("p_frozen_ch0", 32'(pmod_io[7:0]), 32'h7F);
        pause = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
